// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing and default threshold constants for the 32x8 FIFO controller
package fifo_pkg;
    localparam int DEPTH = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W = 6;
    localparam int AF_LEVEL_DEF = 28;
    localparam int AE_LEVEL_DEF = 4;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: ADDR_W+1 bit wrap counter; the top bit toggles each time the row address rolls over
//   Clk   - clock, rising edge
//   Reset - asynchronous active-high clear
//   Inc   - advance by one on the next rising edge
//   Ptr   - {wrap bit, row address}
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Inc,
    output logic [ADDR_W:0]   Ptr
);
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) Ptr <= '0;
        else if (Inc) Ptr <= Ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl_32.sv
// fifo_ctrl_32: pointer, flag and sticky-error controller for the 32x8 structural FIFO
//   Clk, Reset           - clock and asynchronous active-high reset
//   Wr, Rd               - push / pop requests, one per cycle while held
//   WrAddr, RdAddr       - RAM write row and head (oldest entry) row
//   WrEn, RdEn           - qualified strobes: request gated by Full / Empty
//   Full, Empty          - 32 / 0 entries held
//   AlmostFull/Empty     - Count >= AF_LEVEL / Count <= AE_LEVEL
//   Count                - occupancy 0..32
//   Overflow, Underflow  - sticky: push while Full / pop while Empty, cleared only by Reset
module fifo_ctrl_32
    import fifo_pkg::*;
#(
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wr,
    input  logic              Rd,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              WrEn,
    output logic              RdEn,
    output logic              Full,
    output logic              Empty,
    output logic              AlmostFull,
    output logic              AlmostEmpty,
    output logic [CNT_W-1:0]  Count,
    output logic              Overflow,
    output logic              Underflow
);
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

    logic [ADDR_W:0] wptr, rptr;

    fifo_ptr u_wptr (.Clk(Clk), .Reset(Reset), .Inc(WrEn), .Ptr(wptr));
    fifo_ptr u_rptr (.Clk(Clk), .Reset(Reset), .Inc(RdEn), .Ptr(rptr));

    assign WrAddr = wptr[ADDR_W-1:0];
    assign RdAddr = rptr[ADDR_W-1:0];
    // Same row with differing wrap bits means the writer is a full lap ahead.
    assign Empty = wptr == rptr;
    assign Full = (WrAddr == RdAddr) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign Count = wptr - rptr;
    assign AlmostFull = Count >= AF_CNT;
    assign AlmostEmpty = Count <= AE_CNT;
    assign WrEn = Wr & ~Full;
    assign RdEn = Rd & ~Empty;

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            Overflow <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow <= Overflow | (Wr & Full);
            Underflow <= Underflow | (Rd & Empty);
        end
endmodule

// File: tb/tb_fifo_ctrl_32.sv
// tb_fifo_ctrl_32: directed self-checking bench for fifo_ctrl_32
module tb_fifo_ctrl_32;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Wr = 1'b0;
    logic       Rd = 1'b0;
    logic [4:0] WrAddr, RdAddr;
    logic       WrEn, RdEn, Full, Empty, AlmostFull, AlmostEmpty, Overflow, Underflow;
    logic [5:0] Count;
    int checks = 0;
    int errors = 0;

    fifo_ctrl_32 dut (
        .Clk(Clk), .Reset(Reset), .Wr(Wr), .Rd(Rd),
        .WrAddr(WrAddr), .RdAddr(RdAddr), .WrEn(WrEn), .RdEn(RdEn),
        .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
        .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int n);
        Wr = 1'b1;
        repeat (n) tick();
        Wr = 1'b0;
    endtask

    task automatic pop(input int n);
        Rd = 1'b1;
        repeat (n) tick();
        Rd = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count"}, int'(Count), 0);
        check({tag, "_empty"}, int'(Empty), 1);
        check({tag, "_full"}, int'(Full), 0);
        check({tag, "_af"}, int'(AlmostFull), 0);
        check({tag, "_ae"}, int'(AlmostEmpty), 1);
        check({tag, "_wraddr"}, int'(WrAddr), 0);
        check({tag, "_rdaddr"}, int'(RdAddr), 0);
        check({tag, "_ovf"}, int'(Overflow), 0);
        check({tag, "_unf"}, int'(Underflow), 0);
    endtask

    initial begin
        #12 Reset = 1'b0;
        tick();
        check_reset("rst");
        check("rst_wren", int'(WrEn), 0);
        check("rst_rden", int'(RdEn), 0);

        Wr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #0 check("fill_wraddr", int'(WrAddr), i);
            check("fill_wren", int'(WrEn), 1);
            tick();
            check("fill_count", int'(Count), i + 1);
            check("fill_af", int'(AlmostFull), (i + 1 >= 28) ? 1 : 0);
            check("fill_empty", int'(Empty), 0);
        end
        check("full_flag", int'(Full), 1);
        check("full_wraddr", int'(WrAddr), 0);
        check("push33_wren", int'(WrEn), 0);
        check("full_ovf_pre", int'(Overflow), 0);
        tick();
        Wr = 1'b0;
        check("push33_ovf", int'(Overflow), 1);
        check("push33_wraddr", int'(WrAddr), 0);
        check("push33_count", int'(Count), 32);

        Rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #0 check("drain_rdaddr", int'(RdAddr), i);
            check("drain_rden", int'(RdEn), 1);
            tick();
            check("drain_count", int'(Count), 31 - i);
            check("drain_ae", int'(AlmostEmpty), (31 - i <= 4) ? 1 : 0);
            check("drain_full", int'(Full), 0);
        end
        check("drain_empty", int'(Empty), 1);
        check("pop33_rden", int'(RdEn), 0);
        tick();
        Rd = 1'b0;
        check("pop33_unf", int'(Underflow), 1);
        check("pop33_count", int'(Count), 0);
        check("pop33_rdaddr", int'(RdAddr), 0);

        pulse_reset();
        #1 check_reset("rst2");
        push(10);
        check("sim_pre_count", int'(Count), 10);
        Wr = 1'b1;
        Rd = 1'b1;
        repeat (5) begin
            tick();
            check("sim_count", int'(Count), 10);
        end
        Wr = 1'b0;
        Rd = 1'b0;
        check("sim_wraddr", int'(WrAddr), 15);
        check("sim_rdaddr", int'(RdAddr), 5);
        push(22);
        check("simf_full", int'(Full), 1);
        Wr = 1'b1;
        Rd = 1'b1;
        #0 check("simf_wren", int'(WrEn), 0);
        check("simf_rden", int'(RdEn), 1);
        tick();
        Wr = 1'b0;
        Rd = 1'b0;
        check("simf_count", int'(Count), 31);
        check("simf_ovf", int'(Overflow), 1);
        check("simf_unf", int'(Underflow), 0);

        pulse_reset();
        Wr = 1'b1;
        Rd = 1'b1;
        #1 check("sime_wren", int'(WrEn), 1);
        check("sime_rden", int'(RdEn), 0);
        tick();
        Wr = 1'b0;
        Rd = 1'b0;
        check("sime_count", int'(Count), 1);
        check("sime_unf", int'(Underflow), 1);
        check("sime_ovf", int'(Overflow), 0);

        pulse_reset();
        push(20);
        pop(20);
        push(20);
        check("wrap_wraddr", int'(WrAddr), 8);
        check("wrap_rdaddr", int'(RdAddr), 20);
        check("wrap_count", int'(Count), 20);
        check("wrap_bits", int'(dut.wptr[5] != dut.rptr[5]), 1);
        check("wrap_full", int'(Full), 0);

        pulse_reset();
        push(33);
        pop(15);
        check("mid_count", int'(Count), 17);
        check("mid_ovf", int'(Overflow), 1);
        #2 Reset = 1'b1;
        #1 check_reset("mid");
        #1 Reset = 1'b0;
        push(1);
        check("post_rst_count", int'(Count), 1);
        check("post_rst_wraddr", int'(WrAddr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl_32.md
# fifo_ctrl_32

Pointer and flag controller for the 32x8 structural FIFO. It accepts push/pop requests and produces the 5-bit write and read row addresses that drive the RAM's 5-to-32 row decoders. It also produces the qualified write/read enables, the occupancy count and the status flags. It sits directly upstream of the RAM32x8 address decode and owns all sequential state of the FIFO; the RAM itself holds only data.

## Interface
- DEPTH, 32: number of entries; fixed to match RAM32x8.
- ADDR_W, 5: row address width; log2(DEPTH).
- AF_LEVEL, 28: AlmostFull asserts when Count >= AF_LEVEL.
- AE_LEVEL, 4: AlmostEmpty asserts when Count <= AE_LEVEL.

- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Wr  input  1  push request.
- Rd  input  1  pop request.
- WrAddr  output  5  write row address to the write-side decoder Select.
- RdAddr  output  5  read row address (head entry) to the read-side decoder Select.
- WrEn  output  1  qualified write strobe to the RAM; combinational, equal to Wr & ~Full.
- RdEn  output  1  qualified pop; combinational, equal to Rd & ~Empty.
- Full  output  1  32 entries held.
- Empty  output  1  0 entries held.
- AlmostFull, AlmostEmpty  output  1 each  threshold flags.
- Count  output  6  occupancy, 0..32.
- Overflow  output  1  sticky; push attempted while Full.
- Underflow  output  1  sticky; pop attempted while Empty.

## Operation
- State:
  - wptr[5:0] and rptr[5:0], each a binary counter with a wrap bit in bit 5.
  - Overflow and Underflow, sticky error registers.
  - WrAddr = wptr[4:0]; RdAddr = rptr[4:0].
- Flags, all derived from the registered pointers with no next-state look-ahead:
  - Empty = (wptr == rptr).
  - Full = (wptr[4:0] == rptr[4:0]) & (wptr[5] != rptr[5]).
  - Count = wptr - rptr, modulo 64 and taken as 6 bits.
- On a rising edge, WrEn increments wptr and RdEn increments rptr. Bit 5 toggles when bits 4:0 roll over from 31 to 0.
- Simultaneous push and pop:
  - Neither Full nor Empty: both pointers advance; Count is unchanged.
  - Full: only the pop is performed; the push is dropped and Overflow is set.
  - Empty: only the push is performed; the pop is dropped and Underflow is set.
- Overflow and Underflow are cleared only by Reset.
- Reset (asynchronous, at any time including mid-burst):
  - wptr = rptr = 0, giving WrAddr = RdAddr = 0 and Count = 0.
  - Empty = 1, Full = 0, AlmostEmpty = 1, AlmostFull = 0.
  - Overflow = Underflow = 0.
  - RAM contents are not cleared and are considered invalid.
- A request held high across several cycles is treated as one request per cycle.

## Timing
- Write: RAM row WrAddr is written at the same edge where WrEn = 1. WrAddr moves to the next row after that edge.
- Read: RdAddr always points at the oldest entry, so read data is valid combinationally through the RAM whenever Empty = 0. The edge where RdEn = 1 consumes that entry.
- Flag latency is 1 cycle after the causing edge; flags are registered-pointer derived.
  - The first push into an empty FIFO makes Empty = 0 in the next cycle.
  - The 32nd push makes Full = 1 in the next cycle.
- Wrap-around: a pointer at bit pattern 0_11111 advances to 1_00000 with no bubble.
- Reset deassertion needs no synchronisation inside this block. The first request is accepted at the first rising edge after Reset falls.

## Structure
- Shared package fifo_pkg holds:
  - DEPTH = 32, ADDR_W = 5, CNT_W = 6.
  - The default threshold constants AF_LEVEL and AE_LEVEL.
- Sub-module fifo_ptr is instantiated twice, once for writes and once for reads.
  - Ports: Clk, Reset, Inc, Ptr[5:0].
  - It is an ADDR_W+1 bit wrap counter with asynchronous active-high reset.
- Flag, count and sticky-error logic live in fifo_ctrl_32 itself.

## Test plan
- Reset then idle: Count = 0, Empty = 1, WrAddr = RdAddr = 0, all other flags 0.
- Fill: 32 consecutive pushes. Expect:
  - WrAddr steps 0..31, then 0.
  - AlmostFull rises after the 28th push.
  - Full = 1 and Count = 32 after the 32nd push.
  - A 33rd push gives WrEn = 0, Overflow = 1 and WrAddr stays at 0.
- Drain from full: 32 pops. Expect:
  - RdAddr steps 0..31.
  - Empty = 1 and Count = 0 at the end.
  - A 33rd pop gives RdEn = 0 and Underflow = 1.
- Simultaneous push and pop:
  - At Count = 10, 5 cycles of Wr = Rd = 1 leave Count = 10 with both addresses advanced by 5.
  - At Full, Wr = Rd = 1 gives Count = 31 and Overflow = 1.
  - At Empty, Wr = Rd = 1 gives Count = 1 and Underflow = 1.
- Wrap: push 20, pop 20, then push 20. Expect WrAddr = 8, RdAddr = 20, Count = 20, and wptr[5] != rptr[5].
- Reset mid-operation: assert Reset between edges at Count = 17 with Overflow set. Expect all outputs at their reset values immediately, without waiting for Clk.
